// File: rtl/decoder_2to4_unit_if.sv
// Select/decode bus for decoder_2to4_unit.
// Signals: en, a (select MSB), b (select LSB) from master;
//          y0..y3 decoded lines and valid back from slave.
// Optional status outputs last_sel/dec_cnt exist when DECODER_2TO4_STATUS_EN is defined.
interface decoder_2to4_unit_if;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 8;

  logic en;
  logic a;
  logic b;
  logic y0;
  logic y1;
  logic y2;
  logic y3;
  logic valid;
`ifdef DECODER_2TO4_STATUS_EN
  logic [SEL_W-1:0] last_sel;
  logic [CNT_W-1:0] dec_cnt;

  modport master (output en, a, b, input y0, y1, y2, y3, valid, last_sel, dec_cnt);
  modport slave  (input en, a, b, output y0, y1, y2, y3, valid, last_sel, dec_cnt);
`else
  modport master (output en, a, b, input y0, y1, y2, y3, valid);
  modport slave  (input en, a, b, output y0, y1, y2, y3, valid);
`endif
endinterface

// File: rtl/decoder_2to4_unit.sv
// Registered 2-to-4 line decoder with enable.
// Ports: clk, rst_n (async active-low), bus (decoder_2to4_unit_if.slave:
//        en/a/b in, y0..y3/valid out).
// Parameters: ACTIVE_LOW_OUT inverts y0..y3; REG_OUT selects 1-cycle
//             registered outputs (1) or combinational outputs (0).
// Optional macro DECODER_2TO4_STATUS_EN adds last_sel and dec_cnt status.
module decoder_2to4_unit #(
  parameter bit ACTIVE_LOW_OUT = 1'b0,
  parameter bit REG_OUT        = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  decoder_2to4_unit_if.slave    bus
);

  localparam int unsigned NUM_OUT = 4;
  localparam int unsigned SEL_W   = 2;

  logic [SEL_W-1:0]   sel_c;
  logic [NUM_OUT-1:0] dec_c;
  logic               valid_c;
  logic [NUM_OUT-1:0] dec_out;
  logic               valid_out;

  // Active-high one-hot decode of the current inputs.
  always_comb begin
    sel_c   = {bus.a, bus.b};
    dec_c   = '0;
    valid_c = 1'b0;
    if (bus.en) begin
      dec_c   = NUM_OUT'(1) << sel_c;
      valid_c = 1'b1;
    end
  end

  generate
    if (REG_OUT) begin : g_reg
      logic [NUM_OUT-1:0] dec_d;
      logic [NUM_OUT-1:0] dec_q;
      logic               valid_d;
      logic               valid_q;

      always_comb begin
        dec_d   = dec_c;
        valid_d = valid_c;
      end

      // Flops hold the active-high form so reset is always all-zero.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dec_q   <= '0;
          valid_q <= 1'b0;
        end else begin
          dec_q   <= dec_d;
          valid_q <= valid_d;
        end
      end

      assign dec_out   = dec_q;
      assign valid_out = valid_q;
    end else begin : g_comb
      // Reset gates the combinational path inactive.
      assign dec_out   = rst_n ? dec_c : '0;
      assign valid_out = rst_n & valid_c;
    end
  endgenerate

  // Polarity inversion is a constant XOR after the flops: no extra glitch path.
  assign {bus.y3, bus.y2, bus.y1, bus.y0} = dec_out ^ {NUM_OUT{ACTIVE_LOW_OUT}};
  assign bus.valid = valid_out;

`ifdef DECODER_2TO4_STATUS_EN
  localparam int unsigned CNT_W = 8;

  logic [SEL_W-1:0] last_sel_d;
  logic [SEL_W-1:0] last_sel_q;
  logic [CNT_W-1:0] dec_cnt_d;
  logic [CNT_W-1:0] dec_cnt_q;

  // Status updates only on enabled edges; counter wraps naturally.
  always_comb begin
    last_sel_d = last_sel_q;
    dec_cnt_d  = dec_cnt_q;
    if (bus.en) begin
      last_sel_d = sel_c;
      dec_cnt_d  = dec_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_sel_q <= '0;
      dec_cnt_q  <= '0;
    end else begin
      last_sel_q <= last_sel_d;
      dec_cnt_q  <= dec_cnt_d;
    end
  end

  assign bus.last_sel = last_sel_q;
  assign bus.dec_cnt  = dec_cnt_q;
`endif

endmodule

// File: tb/tb_decoder_2to4_unit.sv
// Bench for decoder_2to4_unit: three instances (registered active-high,
// registered active-low, combinational) driven from the same inputs and
// checked against a behavioural model of the decode rules.
module tb_decoder_2to4_unit;

  logic clk;
  logic rst_n;
  logic en_r;
  logic a_r;
  logic b_r;

  int tests;
  int fails;

  // Model state for the registered instances.
  logic exp_en;
  int   exp_sel;
  int   m_cnt;
  int   m_last;

  decoder_2to4_unit_if if_d ();
  decoder_2to4_unit_if if_al ();
  decoder_2to4_unit_if if_cb ();

  assign if_d.en  = en_r;
  assign if_d.a   = a_r;
  assign if_d.b   = b_r;
  assign if_al.en = en_r;
  assign if_al.a  = a_r;
  assign if_al.b  = b_r;
  assign if_cb.en = en_r;
  assign if_cb.a  = a_r;
  assign if_cb.b  = b_r;

  decoder_2to4_unit #(.ACTIVE_LOW_OUT(1'b0), .REG_OUT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(if_d)
  );
  decoder_2to4_unit #(.ACTIVE_LOW_OUT(1'b1), .REG_OUT(1'b1)) dut_al (
    .clk(clk), .rst_n(rst_n), .bus(if_al)
  );
  decoder_2to4_unit #(.ACTIVE_LOW_OUT(1'b0), .REG_OUT(1'b0)) dut_cb (
    .clk(clk), .rst_n(rst_n), .bus(if_cb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Line N is asserted only when enabled and the select number equals N.
  function automatic logic [3:0] ref_vec(input logic e, input int s);
    logic [3:0] v;
    for (int n = 0; n < 4; n++) v[n] = (e === 1'b1) && (s == n);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reg();
    logic [3:0] r;
    r = ref_vec(exp_en, exp_sel);
    chk("reg_y",    {4'b0, if_d.y3, if_d.y2, if_d.y1, if_d.y0}, {4'b0, r});
    chk("reg_valid", {7'b0, if_d.valid}, {7'b0, exp_en});
    chk("al_y",     {4'b0, if_al.y3, if_al.y2, if_al.y1, if_al.y0}, {4'b0, ~r});
    chk("al_valid", {7'b0, if_al.valid}, {7'b0, exp_en});
`ifdef DECODER_2TO4_STATUS_EN
    chk("dec_cnt",     if_d.dec_cnt, 8'(m_cnt % 256));
    chk("last_sel",    {6'b0, if_d.last_sel}, 8'(m_last));
    chk("cb_dec_cnt",  if_cb.dec_cnt, 8'(m_cnt % 256));
    chk("cb_last_sel", {6'b0, if_cb.last_sel}, 8'(m_last));
`endif
  endtask

  task automatic check_comb();
    logic [3:0] r;
    logic       live;
    live = rst_n & en_r;
    r = ref_vec(live, 2 * int'(a_r) + int'(b_r));
    chk("cb_y",     {4'b0, if_cb.y3, if_cb.y2, if_cb.y1, if_cb.y0}, {4'b0, r});
    chk("cb_valid", {7'b0, if_cb.valid}, {7'b0, live});
  endtask

  task automatic model_reset();
    exp_en  = 1'b0;
    exp_sel = 0;
    m_cnt   = 0;
    m_last  = 0;
  endtask

  // Drive one input set, check the combinational view, then the registered view.
  task automatic step(input logic e, input logic ai, input logic bi, input bit do_chk);
    @(negedge clk);
    en_r = e; a_r = ai; b_r = bi;
    #1;
    if (do_chk) check_comb();
    @(posedge clk);
    #1;
    exp_en  = e;
    exp_sel = 2 * int'(ai) + int'(bi);
    if (e) begin
      m_cnt++;
      m_last = exp_sel;
    end
    if (do_chk) check_reg();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    model_reset();
    rst_n = 1'b1;
    en_r = 1'b1; a_r = 1'b1; b_r = 1'b1;

    // Reset takes effect with no clock edge.
    #2 rst_n = 1'b0;
    #1;
    check_reg();
    check_comb();

    @(negedge clk);
    rst_n = 1'b1;

    // Sweep all selects.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);

    // Enable gating then release.
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);

    // Combinational path reacts mid-cycle before any edge.
    @(negedge clk);
    en_r = 1'b1; a_r = 1'b0; b_r = 1'b0;
    #1 check_comb();
    a_r = 1'b1; b_r = 1'b1;
    #1 check_comb();
    chk("cb_y3_mid", {7'b0, if_cb.y3}, 8'd1);
    @(posedge clk);
    #1;
    exp_en = 1'b1; exp_sel = 3; m_cnt++; m_last = 3;
    check_reg();

    // Randomized traffic.
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'b1);

    // Asynchronous reset mid-cycle aborts the outputs at once.
    step(1'b1, 1'b0, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_reg();
    check_comb();
    @(negedge clk);
    rst_n = 1'b1;

    // First enabled edge after reset decodes.
    step(1'b1, 1'b1, 1'b0, 1'b1);

`ifdef DECODER_2TO4_STATUS_EN
    // Five enabled decodes ending with sel=2.
    @(negedge clk);
    rst_n = 1'b0;
    #1 model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("st5_cnt", if_d.dec_cnt, 8'd5);
    chk("st5_last", {6'b0, if_d.last_sel}, 8'd2);

    // 256 enabled cycles from reset wrap the counter to zero.
    @(negedge clk);
    rst_n = 1'b0;
    #1 model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++)
      step(1'b1, 1'($urandom), 1'($urandom), 1'b0);
    chk("wrap_cnt", if_d.dec_cnt, 8'd0);
    check_reg();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decoder_2to4_unit.md
Name: decoder_2to4_unit

Overview:
- Registered 2-to-4 line decoder with enable.
- Select inputs a (MSB) and b (LSB) pick exactly one of y0..y3 to assert.
- Used as a small address/select decoder that feeds chip-select or mux-select logic downstream.
- Outputs are one-hot, or all inactive, and leave the block on registered, glitch-free paths.

Parameters:
- ACTIVE_LOW_OUT, default 0: 0 means an asserted output is 1; 1 means an asserted output is 0 and all levels on y0..y3 are inverted.
- REG_OUT, default 1: 1 means outputs are registered (1-cycle latency); 0 means outputs are combinational from a/b/en, and valid is also combinational.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  decode enable; 0 forces all outputs inactive.
- a  input  1  select MSB.
- b  input  1  select LSB.
- y0  output  1  asserted when {a,b}=2'b00 and en=1.
- y1  output  1  asserted when {a,b}=2'b01 and en=1.
- y2  output  1  asserted when {a,b}=2'b10 and en=1.
- y3  output  1  asserted when {a,b}=2'b11 and en=1.
- valid  output  1  1 when one of y0..y3 is asserted.

Behaviour:
- Select index sel = {a,b}; a is bit 1, b is bit 0.
- Decode function:
  - en=1: yN asserted for N=sel; the other three outputs inactive.
  - en=0: all four outputs inactive, valid=0.
- Inactive level is 0 when ACTIVE_LOW_OUT=0 and 1 when ACTIVE_LOW_OUT=1; valid is always active-high.
- REG_OUT=1:
  - a, b and en are sampled on the rising clk edge; outputs update at that edge, so latency is exactly 1 cycle.
  - A new select every cycle is supported, with no throughput gaps.
- REG_OUT=0: outputs follow the inputs combinationally with 0 latency; clk is unused except by the optional feature.
- Reset:
  - rst_n low immediately, without waiting for clk, drives y0..y3 to the inactive level and valid to 0.
  - Asserting reset mid-operation aborts the current output at once.
  - After rst_n rises, the first rising edge with en=1 produces a valid decode.
  - In REG_OUT=0 mode, rst_n low also gates the outputs inactive.
- Invariant: at most one of y0..y3 is in the asserted state at any time. valid equals the OR of the asserted-state outputs.
- X/Z on a or b while en=1 is illegal input. Outputs are undefined for that cycle only; state does not persist beyond that cycle.
- No other internal state exists apart from the optional feature.

Optional Feature:
- Macro DECODER_2TO4_STATUS_EN.
- When defined, two extra output ports are added:
  - last_sel [1:0]: the sel value of the most recent decode with en=1.
  - dec_cnt [7:0]: counts clock edges at which en=1, and wraps 255 to 0.
- Both are registered on clk in every REG_OUT mode, and both reset to 0 asynchronously on rst_n low.
- When en=0, both hold their values.
- When the macro is not defined, neither port exists and there is no extra logic.

Test Plan:
- Reset: rst_n=0 with a=1, b=1, en=1 -> y0..y3=0000 and valid=0 immediately, with no clock edge needed.
- Full sweep, en=1, REG_OUT=1, ACTIVE_LOW_OUT=0: {a,b}=00,01,10,11 on successive cycles -> one cycle later y3..y0=0001, 0010, 0100, 1000 and valid=1 each cycle.
- Enable gating: a=1, b=0, en=0 -> y3..y0=0000 and valid=0; raise en -> 0100 on the next edge.
- Active-low build, ACTIVE_LOW_OUT=1: {a,b}=01, en=1 -> y3..y0=1101; during reset all outputs read 1111.
- Combinational build, REG_OUT=0: change {a,b} from 00 to 11 mid-cycle -> y3 asserts within the same delta, before any clock edge.
- With DECODER_2TO4_STATUS_EN defined: five enabled decodes ending with sel=10 -> last_sel=2'b10 and dec_cnt=5; 256 enabled cycles from reset -> dec_cnt=0.
